// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns byte/half/word loads and stores into word-aligned
// bus transactions with byte enables, stalls the CPU while the access is in flight.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memDataSize,
    input  logic        memBitExt,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        access_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateType;

    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_BYTE = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;

    stateType   state;
    stateType   nextState;
    logic [CNT_W-1:0] waitCnt;

    logic [1:0] latSize;
    logic       latExt;
    logic [1:0] latLo;

    logic        access;
    logic        invalidReq;
    logic        timeoutHit;
    logic [3:0]  storeBe;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic [15:0] halfLane;
    logic [7:0]  byteLane;

    assign access   = memRead | memWrite;
    assign dbgState = state;

    always_comb begin
        invalidReq = 1'b0;
        if (memRead && memWrite)
            invalidReq = 1'b1;
        if (memDataSize == SIZE_BAD)
            invalidReq = 1'b1;
        if (memDataSize == SIZE_WORD && addr[1:0] != 2'b00)
            invalidReq = 1'b1;
        if (memDataSize == SIZE_HALF && addr[0])
            invalidReq = 1'b1;
    end

    assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Store data is replicated across all lanes; the byte enables pick the real one.
    always_comb begin
        storeBe   = 4'b1111;
        storeData = 32'h0;
        if (memWrite) begin
            case (memDataSize)
                SIZE_HALF: begin
                    storeBe   = addr[1] ? 4'b1100 : 4'b0011;
                    storeData = {2{wdata[15:0]}};
                end
                SIZE_BYTE: begin
                    storeBe   = 4'b0001 << addr[1:0];
                    storeData = {4{wdata[7:0]}};
                end
                default: begin
                    storeBe   = 4'b1111;
                    storeData = wdata;
                end
            endcase
        end
    end

    always_comb begin
        halfLane = latLo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byteLane = 8'h0;
        case (latLo)
            2'd0:    byteLane = mem_rdata[7:0];
            2'd1:    byteLane = mem_rdata[15:8];
            2'd2:    byteLane = mem_rdata[23:16];
            default: byteLane = mem_rdata[31:24];
        endcase
    end

    // latExt=1 means zero extension.
    always_comb begin
        loadData = mem_rdata;
        case (latSize)
            SIZE_HALF: loadData = latExt ? {16'h0, halfLane} : {{16{halfLane[15]}}, halfLane};
            SIZE_BYTE: loadData = latExt ? {24'h0, byteLane} : {{24{byteLane[7]}}, byteLane};
            default:   loadData = mem_rdata;
        endcase
    end

    // Bus handshake: mem_req rises at the edge that leaves IDLE, stays high with all
    // bus outputs stable, and falls at the edge that samples mem_ack (or the timeout).
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access && !invalidReq) begin
                    stall     = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || timeoutHit)
                    nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (rst)
            stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            waitCnt    <= '0;
            latSize    <= 2'd0;
            latExt     <= 1'b0;
            latLo      <= 2'd0;
            rdata      <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 30'h0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
            access_err <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= nextState;
            access_err <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (invalidReq) begin
                            access_err <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= memWrite;
                            mem_addr  <= addr[31:2];
                            mem_be    <= storeBe;
                            mem_wdata <= storeData;
                            latSize   <= memDataSize;
                            latExt    <= memBitExt;
                            latLo     <= addr[1:0];
                            waitCnt   <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        if (!mem_we)
                            rdata <= loadData;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'h0;
                    end else if (timeoutHit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'h0;
                        rdata   <= 32'h0;
                        bus_err <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random accesses, expectations queued at
// issue time and checked by an independent monitor on the falling clock edge.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_data_size;
  logic        mem_bit_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        access_err;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .memRead(mem_read), .memWrite(mem_write),
    .memDataSize(mem_data_size), .memBitExt(mem_bit_ext),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall),
    .access_err(access_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbgState(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks_total = 0;
  int checks_passed = 0;
  logic [66:0] bus_exp_q[$];    // {word addr, we, be, wdata}
  logic [32:0] done_exp_q[$];   // {bus_err, rdata}
  logic [7:0]  stall_exp_q[$];  // stall run length
  logic [31:0] err_exp_q[$];    // rdata expected while access_err is high
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] load_model(input logic [1:0] size, input logic ext,
                                             input logic [1:0] lo, input logic [31:0] bus);
    logic [31:0] v;
    if (size == 2'd0) return bus;
    v = bus >> (8 * int'(lo));
    if (size == 2'd1) begin
      v = v & 32'h0000FFFF;
      if (!ext && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = v & 32'h000000FF;
      if (!ext && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_data_size = 2'd0; mem_bit_ext = 1'b0;
    addr = $urandom(); wdata = $urandom(); mem_ack = 1'b0; mem_rdata = $urandom();
  endtask

  // driver: ack_dly < T acks in that BUSY cycle, ack_dly == T acks in DONE (late),
  // larger values never ack
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                           input logic ext, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] bus, input int ack_dly);
    bit bad;
    int busy_cycles;
    logic [3:0] be_x;
    logic [31:0] wd_x;
    bad = (rd && wr) || size == 2'd3 || (size == 2'd0 && a[1:0] != 2'd0) ||
          (size == 2'd1 && a[0]);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_data_size = size; mem_bit_ext = ext;
    addr = a; wdata = wd; mem_ack = 1'b0; mem_rdata = $urandom();
    if (bad) begin
      err_exp_q.push_back(model_rdata);
      @(posedge clk); #1;
      clear_inputs();
      return;
    end
    busy_cycles = (ack_dly < T) ? ack_dly + 1 : T;
    if (rd) begin
      be_x = 4'hF; wd_x = 32'h0;
    end else begin
      case (size)
        2'd1:    begin be_x = 4'b0011 << a[1:0]; wd_x = (wd & 32'hFFFF) * 32'h00010001; end
        2'd2:    begin be_x = 4'b0001 << a[1:0]; wd_x = (wd & 32'hFF) * 32'h01010101; end
        default: begin be_x = 4'hF; wd_x = wd; end
      endcase
    end
    bus_exp_q.push_back({a[31:2], wr, be_x, wd_x});
    if (ack_dly < T) begin
      if (rd) model_rdata = load_model(size, ext, a[1:0], bus);
      done_exp_q.push_back({1'b0, model_rdata});
    end else begin
      model_rdata = 32'h0;
      done_exp_q.push_back({1'b1, model_rdata});
    end
    stall_exp_q.push_back(8'(busy_cycles + 1));
    for (int i = 0; i <= busy_cycles; i++) begin
      @(posedge clk); #1;
      mem_ack = (i == ack_dly);
      mem_rdata = (i == ack_dly) ? bus : $urandom();
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // monitor
  logic prev_stall = 1'b0;
  logic prev_req = 1'b0;
  int   run_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0; prev_req = 1'b0; run_len = 0;
    end else begin
      if (stall) run_len++;
      if (mem_req && !prev_req) begin
        check("bus_req_expected", 67'(bus_exp_q.size() != 0), 67'd1);
        if (bus_exp_q.size() != 0)
          check("bus_req", {mem_addr, mem_we, mem_be, mem_wdata}, bus_exp_q.pop_front());
      end
      if (prev_stall && !stall) begin
        check("done_expected", 67'(done_exp_q.size() != 0), 67'd1);
        if (done_exp_q.size() != 0)
          check("done_rdata_buserr", {bus_err, rdata}, done_exp_q.pop_front());
        check("done_req_low", {mem_req, mem_be}, 67'd0);
        if (stall_exp_q.size() != 0)
          check("stall_cycles", 67'(run_len), stall_exp_q.pop_front());
        run_len = 0;
      end else if (bus_err) begin
        check("stray_bus_err", 67'(bus_err), 67'd0);
      end
      if (access_err) begin
        check("access_err_expected", 67'(err_exp_q.size() != 0), 67'd1);
        if (err_exp_q.size() != 0)
          check("access_err_rdata", rdata, err_exp_q.pop_front());
        check("access_err_quiet", {mem_req, stall, prev_stall}, 67'd0);
      end
      prev_stall = stall;
      prev_req = mem_req;
    end
  end

  // stimulus
  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_bus", {mem_req, mem_we, mem_addr, mem_be}, 67'd0);
    check("reset_data", {rdata, mem_wdata}, 67'd0);
    check("reset_flags", {access_err, bus_err, stall, dbg_state}, 67'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed cases
    do_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h203, 32'h0, 32'h80FF7F01, 0);
    do_access(1'b1, 1'b0, 2'd2, 1'b1, 32'h203, 32'h0, 32'h80FF7F01, 1);
    do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h201, 32'h0, 32'h80FF7F01, 3);
    do_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 32'h0, 1);
    do_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h8001FFFF, 0);
    do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h0, 0);
    do_access(1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h300, 32'h0, 32'h12345678, T);
    do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, T - 1);
    do_access(1'b1, 1'b1, 2'd0, 1'b0, 32'h308, 32'h0, 32'h0, 0);

    // reset during the second BUSY cycle
    @(posedge clk); #1;
    mem_read = 1'b1; mem_data_size = 2'd0; addr = 32'h400;
    bus_exp_q.push_back({30'h100, 1'b0, 4'hF, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_reset_bus", {mem_req, mem_we, mem_addr, mem_be}, 67'd0);
    check("busy_reset_data", {rdata, mem_wdata}, 67'd0);
    check("busy_reset_flags", {access_err, bus_err, stall, dbg_state}, 67'd0);
    model_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    mem_ack = 1'b1;
    @(negedge clk);
    check("late_ack_ignored", {mem_req, stall, dbg_state, bus_err}, 67'd0);
    do_access(1'b1, 1'b0, 2'd1, 1'b1, 32'h502, 32'h0, 32'h9ABC1234, 1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      logic rd, wr, ext;
      logic [1:0] size;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      if ($urandom_range(0, 15) == 0) begin rd = 1'b1; wr = 1'b1; end
      size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ext = 1'($urandom_range(0, 1));
      a = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd0) a[1:0] = 2'd0;
        if (size == 2'd1) a[0] = 1'b0;
      end
      do_access(rd, wr, size, ext, a, $urandom(), $urandom(), $urandom_range(0, T + 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bus_q_drained", 67'(bus_exp_q.size()), 67'd0);
    check("done_q_drained", 67'(done_exp_q.size()), 67'd0);
    check("stall_q_drained", 67'(stall_exp_q.size()), 67'd0);
    check("err_q_drained", 67'(err_exp_q.size()), 67'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
